ulpb_rx_fifo: RTL and testbench

Receive-side message buffer between a ULPB bus node's RX handshake and the local layer controller. It is the inbound counterpart of the node-top TX FIFO. Each message (address + data) delivered by the node over a four-phase REQ/ACK handshake is stored in a DEPTH-entry FIFO. Messages are presented to the layer controller in arrival order over a second four-phase handshake. When the FIFO is full, the bus side is back-pressured and no message is dropped; the event is recorded in a sticky OVERFLOW flag.

---
 rtl/ulpb_rx_fifo_if.sv | 14 +
 rtl/ulpb_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_ulpb_rx_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpb_rx_fifo_if.sv
// Four-phase REQ/ACK message channel carrying one {addr,data} word.
// The master drives the message and REQ; the slave returns ACK.
interface ulpb_rx_fifo_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  req;
  logic                  ack;

  modport master (output addr, output data, output req, input ack);
  modport slave  (input addr, input data, input req, output ack);
endinterface

// File: rtl/ulpb_rx_fifo.sv
// Inbound ULPB message buffer: accepts node RX messages over four-phase REQ/ACK,
// queues them in a DEPTH-entry FIFO and presents them in order to the layer controller.
module ulpb_rx_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  ulpb_rx_fifo_if.slave          bus_if,
  ulpb_rx_fifo_if.master         lc_if,
  input  logic                   clr_overflow_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("ulpb_rx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {
    W_IDLE,
    W_ACK
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT
  } r_state_e;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ack_q, ack_d;
  logic                  lc_req_q, lc_req_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  stall;
  logic                  load;
  logic                  pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    w_state_d = w_state_q;
    ack_d     = ack_q;
    wr_en     = 1'b0;
    stall     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus_if.req) begin
          if (!full) begin
            wr_en     = 1'b1;
            ack_d     = 1'b1;
            w_state_d = W_ACK;
          end else begin
            stall = 1'b1;
          end
        end
      end
      W_ACK: begin
        if (!bus_if.req) begin
          ack_d     = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        ack_d     = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    lc_req_d  = lc_req_q;
    load      = 1'b0;
    pop       = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          lc_req_d  = 1'b1;
          r_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (lc_if.ack) begin
          pop       = 1'b1;
          lc_req_d  = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // Wait for the controller to release ACK before presenting the next message.
        if (!lc_if.ack) begin
          r_state_d = R_IDLE;
        end
      end
      default: begin
        lc_req_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A stall in the same cycle as a clear must leave the flag set.
    if (stall) begin
      ovf_d = 1'b1;
    end else if (clr_overflow_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {bus_if.addr, bus_if.data};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      lc_req_q  <= 1'b0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      lc_req_q  <= lc_req_d;
      ovf_q     <= ovf_d;
      if (load) begin
        {addr_q, data_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  assign bus_if.ack = ack_q;
  assign lc_if.req  = lc_req_q;
  assign lc_if.addr = addr_q;
  assign lc_if.data = data_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ulpb_rx_fifo.sv
// Scoreboard bench for ulpb_rx_fifo: messages are queued when driven and
// compared when the layer-controller side presents them.
module tb_ulpb_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       clr_ovf;
  logic [3:0] count;
  logic       ovf;

  logic       lc_auto;
  logic       auto_ack;
  logic       man_ack;
  int unsigned lc_dly_max;

  int checks;
  int errors;

  logic [39:0] exp_q[$];
  logic [39:0] held;
  logic        lc_req_prev;

  ulpb_rx_fifo_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_if ();
  ulpb_rx_fifo_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) lc_if ();

  assign lc_if.ack = lc_auto ? auto_ack : man_ack;

  ulpb_rx_fifo #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bus_if         (bus_if),
    .lc_if          (lc_if),
    .clr_overflow_i (clr_ovf),
    .count_o        (count),
    .overflow_o     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare on each new presentation, and hold-stability while REQ stays high.
  initial lc_req_prev = 1'b0;
  always @(negedge clk) begin
    if (lc_if.req === 1'b1 && !lc_req_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_msg", 64'd1, 64'd0);
      end else begin
        held = exp_q.pop_front();
        check("lc_msg", {24'd0, lc_if.addr, lc_if.data}, {24'd0, held});
        $display("LC  addr=0x%02h data=0x%08h", lc_if.addr, lc_if.data);
      end
    end else if (lc_if.req === 1'b1 && lc_req_prev) begin
      check("lc_hold", {24'd0, lc_if.addr, lc_if.data}, {24'd0, held});
    end
    lc_req_prev = (lc_if.req === 1'b1);
  end

  initial begin
    auto_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (lc_auto && lc_if.req === 1'b1 && !auto_ack) begin
        repeat ($urandom_range(0, lc_dly_max)) @(negedge clk);
        auto_ack = 1'b1;
        for (int n = 0; n < 100 && lc_if.req === 1'b1; n++) @(negedge clk);
        auto_ack = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus_if.addr = a;
    bus_if.data = d;
    bus_if.req  = 1'b1;
    exp_q.push_back({a, d});
    $display("BUS addr=0x%02h data=0x%08h", a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.ack !== 1'b1 && n < 200);
    if (bus_if.ack !== 1'b1) check("ack_timeout", 64'd0, 64'd1);
    bus_if.req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.ack !== 1'b0 && n < 200);
    if (bus_if.ack !== 1'b0) check("ack_low_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((count != 0 || lc_if.req === 1'b1 || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    clr_ovf    = 1'b0;
    lc_auto    = 1'b0;
    man_ack    = 1'b0;
    lc_dly_max = 0;
    bus_if.req  = 1'b0;
    bus_if.addr = '0;
    bus_if.data = '0;

    repeat (2) @(negedge clk);
    check("rst_ack", 64'(bus_if.ack), 64'd0);
    check("rst_lcreq", 64'(lc_if.req), 64'd0);
    check("rst_addr", 64'(lc_if.addr), 64'd0);
    check("rst_data", 64'(lc_if.data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    // Single message with exact latencies
    @(negedge clk);
    bus_if.addr = 8'h12;
    bus_if.data = 32'hDEADBEEF;
    bus_if.req  = 1'b1;
    exp_q.push_back({8'h12, 32'hDEADBEEF});
    @(negedge clk);
    check("single_ack", 64'(bus_if.ack), 64'd1);
    check("single_count1", 64'(count), 64'd1);
    check("single_lcreq_early", 64'(lc_if.req), 64'd0);
    @(negedge clk);
    check("single_lcreq", 64'(lc_if.req), 64'd1);
    check("single_addr", 64'(lc_if.addr), 64'h12);
    check("single_data", 64'(lc_if.data), 64'hDEADBEEF);
    bus_if.req = 1'b0;
    @(negedge clk);
    check("single_ack_low", 64'(bus_if.ack), 64'd0);
    man_ack = 1'b1;
    @(negedge clk);
    check("single_lcreq_low", 64'(lc_if.req), 64'd0);
    check("single_count0", 64'(count), 64'd0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Fill, stall, overflow set-wins-over-clear, release on pop
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 32'hA000_0000 + i);
    check("fill_count", 64'(count), 64'd8);
    @(negedge clk);
    bus_if.addr = 8'h28;
    bus_if.data = 32'hA000_0008;
    bus_if.req  = 1'b1;
    exp_q.push_back({8'h28, 32'hA000_0008});
    repeat (3) @(negedge clk);
    check("full_ack", 64'(bus_if.ack), 64'd0);
    check("full_ovf", 64'(ovf), 64'd1);
    check("full_count", 64'(count), 64'd8);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 64'(ovf), 64'd1);
    man_ack = 1'b1;
    @(negedge clk);
    check("pop_count", 64'(count), 64'd7);
    check("pop_ack_still0", 64'(bus_if.ack), 64'd0);
    @(negedge clk);
    check("release_ack", 64'(bus_if.ack), 64'd1);
    check("release_count", 64'(count), 64'd8);
    man_ack = 1'b0;
    bus_if.req = 1'b0;
    repeat (2) @(negedge clk);
    lc_auto = 1'b1;
    wait_drain();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Simultaneous write and pop at COUNT=3
    lc_auto = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 32'hB000_0000 + i);
    check("sim_count_pre", 64'(count), 64'd3);
    @(negedge clk);
    bus_if.addr = 8'h43;
    bus_if.data = 32'hB000_0003;
    bus_if.req  = 1'b1;
    exp_q.push_back({8'h43, 32'hB000_0003});
    man_ack = 1'b1;
    @(negedge clk);
    check("sim_count", 64'(count), 64'd3);
    check("sim_ack", 64'(bus_if.ack), 64'd1);
    check("sim_lcreq", 64'(lc_if.req), 64'd0);
    man_ack = 1'b0;
    bus_if.req = 1'b0;
    repeat (2) @(negedge clk);
    lc_auto = 1'b1;
    wait_drain();

    // Streamed wrap-around with random controller delay
    lc_dly_max = 3;
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), $urandom);
    wait_drain();
    lc_dly_max = 0;

    // Reset in the middle of both handshakes
    lc_auto = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 32'hC000_0000 + i);
    @(negedge clk);
    bus_if.addr = 8'h64;
    bus_if.data = 32'hC000_0004;
    bus_if.req  = 1'b1;
    @(negedge clk);
    check("mid_ack", 64'(bus_if.ack), 64'd1);
    check("mid_count", 64'(count), 64'd5);
    check("mid_lcreq", 64'(lc_if.req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("mrst_ack", 64'(bus_if.ack), 64'd0);
    check("mrst_lcreq", 64'(lc_if.req), 64'd0);
    check("mrst_addr", 64'(lc_if.addr), 64'd0);
    check("mrst_data", 64'(lc_if.data), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    bus_if.req = 1'b0;
    rst_n = 1'b1;
    lc_auto = 1'b1;
    @(negedge clk);
    send(8'h77, 32'h1234_5678);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
